// File: rtl/prbg_pkg.sv
// Shared types and constants for the prbg_lfsr pseudo-random bit generator.
// Holds the FSM encoding, the default polynomials and seeds, and the feedback helper.
package prbg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RECOVER
    } fsm_t;

    // Maximal-length Fibonacci masks: bit i set means state[i] enters the feedback XOR.
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [7:0]  SEED_W8  = 8'h01;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [15:0] SEED_W16 = 16'h0001;

    function automatic logic xor_reduce(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/prbg_period_cnt.sv
// Emit counter for prbg_lfsr: counts emitted bits modulo 2^WIDTH-1 and
// pulses period_done on the edge that emits the last bit of a full period.
module prbg_period_cnt #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic res,
    input  logic clear,
    input  logic inc,
    output logic period_done
);

    localparam logic [WIDTH-1:0] CNT_MAX = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            count       <= '0;
            period_done <= 1'b0;
        end else if (clear) begin
            count       <= '0;
            period_done <= 1'b0;
        end else if (inc) begin
            count       <= (count == CNT_MAX) ? '0 : count + 1'b1;
            period_done <= (count == CNT_MAX);
        end else begin
            period_done <= 1'b0;
        end
    end

endmodule

// File: rtl/prbg_lfsr.sv
// Fibonacci LFSR bit generator with seed load, zero-lockup recovery and period pulse.
// Optional macro PRBG_ERR_INJECT_EN adds err_inject, which inverts the emitted bit only.
module prbg_lfsr
    import prbg_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = TAPS_W8,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = SEED_W8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
`ifdef PRBG_ERR_INJECT_EN
    input  logic             err_inject,
`endif
    output logic             out_bit,
    output logic             out_valid,
    output logic [WIDTH-1:0] state_out,
    output logic             period_done,
    output logic             seed_err
);

    fsm_t             fsm, fsm_next;
    logic [WIDTH-1:0] state;
    logic             state_zero;
    logic             fb;
    logic             emit;
    logic             recover;
    logic             inj;

`ifdef PRBG_ERR_INJECT_EN
    assign inj = err_inject;
`else
    assign inj = 1'b0;
`endif

    assign state_zero = (state == '0);
    assign fb         = xor_reduce(32'(state & TAPS));
    assign state_out  = state;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // Seed load outranks everything; a zero state diverts to RECOVER from any other state.
    always_comb begin
        fsm_next = fsm;
        if (seed_load) begin
            fsm_next = IDLE;
        end else if (fsm == RECOVER) begin
            fsm_next = IDLE;
        end else if (state_zero) begin
            fsm_next = RECOVER;
        end else begin
            case (fsm)
                IDLE:    fsm_next = enable ? RUN : IDLE;
                RUN:     fsm_next = enable ? RUN : IDLE;
                default: fsm_next = IDLE;
            endcase
        end
    end

    always_comb begin
        emit    = 1'b0;
        recover = 1'b0;
        if (!seed_load) begin
            case (fsm)
                IDLE, RUN: emit    = enable && !state_zero;
                RECOVER:   recover = 1'b1;
                default:   emit    = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= DEFAULT_SEED;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            seed_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            seed_err  <= 1'b0;
            if (seed_load) begin
                state    <= (seed == '0) ? DEFAULT_SEED : seed;
                seed_err <= (seed == '0);
            end else if (recover) begin
                state    <= DEFAULT_SEED;
                seed_err <= 1'b1;
            end else if (emit) begin
                out_bit   <= state[WIDTH-1] ^ inj;
                out_valid <= 1'b1;
                state     <= {state[WIDTH-2:0], fb};
            end
        end
    end

    prbg_period_cnt #(
        .WIDTH(WIDTH)
    ) u_period_cnt (
        .clk         (clk),
        .res         (res),
        .clear       (seed_load || recover),
        .inc         (emit),
        .period_done (period_done)
    );

endmodule

// File: tb/tb_prbg_lfsr.sv
// Self-checking bench for prbg_lfsr (default build, WIDTH=8, taps 8'hB8).
// Directed vector table, hand-written period/reset sequences, then random traffic vs a model.
module tb_prbg_lfsr;

    logic       clk = 1'b0;
    logic       res;
    logic       enable;
    logic       seed_load;
    logic [7:0] seed;
    logic       out_bit;
    logic       out_valid;
    logic [7:0] state_out;
    logic       period_done;
    logic       seed_err;

    int checks = 0;
    int errors = 0;

    prbg_lfsr #(
        .WIDTH        (8),
        .TAPS         (8'hB8),
        .DEFAULT_SEED (8'h01)
    ) dut (
        .clk         (clk),
        .res         (res),
        .enable      (enable),
        .seed_load   (seed_load),
        .seed        (seed),
        .out_bit     (out_bit),
        .out_valid   (out_valid),
        .state_out   (state_out),
        .period_done (period_done),
        .seed_err    (seed_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] sd;
        logic       en;
        logic [7:0] e_state;
        logic       e_bit;
        logic       e_valid;
        logic       e_pd;
        logic       e_err;
    } vec_t;

    vec_t vecs[12];

    // Reference model: bits emitted since load tracked as a plain integer count.
    logic [7:0] m_state;
    logic       m_bit, m_valid, m_pd, m_err;
    int         m_emitted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic ld, input logic [7:0] sd, input logic en);
        seed_load = ld;
        seed      = sd;
        enable    = en;
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge(input logic ld, input logic [7:0] sd, input logic en);
        m_valid = 1'b0;
        m_pd    = 1'b0;
        m_err   = 1'b0;
        if (ld) begin
            m_state   = (sd == 8'h00) ? 8'h01 : sd;
            m_err     = (sd == 8'h00);
            m_emitted = 0;
        end else if (en) begin
            m_bit     = m_state[7];
            m_valid   = 1'b1;
            m_emitted = m_emitted + 1;
            m_pd      = (m_emitted % 255) == 0;
            m_state   = 8'((int'(m_state) * 2) % 256 + ($countones(m_state & 8'hB8) % 2));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 8'h23, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h47, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 8'h4A, 1'b1, 1'b1, 1'b0, 1'b0};

        res = 1'b1; enable = 1'b0; seed_load = 1'b0; seed = 8'h00;
        @(posedge clk);
        #2;
        chk("rst_state", state_out, 8'h01);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_bit", out_bit, 1'b0);
        res = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        chk("idle_state", state_out, 8'h01);
        chk("idle_valid", out_valid, 1'b0);
        chk("idle_pd", period_done, 1'b0);
        chk("idle_err", seed_err, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].sd, vecs[i].en);
            chk($sformatf("vec%0d_state", i), state_out, vecs[i].e_state);
            chk($sformatf("vec%0d_bit", i), out_bit, vecs[i].e_bit);
            chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_pd", i), period_done, vecs[i].e_pd);
            chk($sformatf("vec%0d_err", i), seed_err, vecs[i].e_err);
        end

        // Full period: period_done only on the 255th bit, state returns to the seed.
        step(1'b1, 8'h01, 1'b0);
        for (int n = 1; n <= 256; n++) begin
            step(1'b0, 8'h00, 1'b1);
            chk($sformatf("period_pd_%0d", n), period_done, (n == 255));
            if (n == 255) chk("period_state", state_out, 8'h01);
        end

        // Asynchronous reset between edges.
        step(1'b0, 8'h00, 1'b1);
        #3;
        res = 1'b1;
        #1;
        chk("arst_state", state_out, 8'h01);
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_bit", out_bit, 1'b0);
        chk("arst_pd", period_done, 1'b0);
        chk("arst_err", seed_err, 1'b0);
        @(negedge clk);
        res = 1'b0;
        step(1'b0, 8'h00, 1'b1);
        chk("restart_state", state_out, 8'h02);
        chk("restart_valid", out_valid, 1'b1);

        // Random traffic against the model, starting from a fresh reset.
        enable = 1'b0; seed_load = 1'b0;
        res = 1'b1;
        #2;
        res = 1'b0;
        m_state = 8'h01; m_bit = 1'b0; m_valid = 1'b0; m_pd = 1'b0; m_err = 1'b0;
        m_emitted = 0;
        for (int c = 0; c < 1500; c++) begin
            logic       r_ld, r_en;
            logic [7:0] r_sd;
            r_ld = ($urandom_range(0, 99) < 3);
            r_en = ($urandom_range(0, 99) < 85);
            r_sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            step(r_ld, r_sd, r_en);
            model_edge(r_ld, r_sd, r_en);
            chk("rnd_state", state_out, m_state);
            chk("rnd_bit", out_bit, m_bit);
            chk("rnd_valid", out_valid, m_valid);
            chk("rnd_pd", period_done, m_pd);
            chk("rnd_err", seed_err, m_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
